// File: rtl/w_clk_module.sv
// Write-side pointer and flag logic for the dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchroniser, and registered full / almost-full / level. Optional W_OVERFLOW_DETECT_EN.
module w_clk_module #(
    parameter int ADDRESS_SIZE       = 4,
    parameter int ALMOST_FULL_THRESH = 2**ADDRESS_SIZE - 2
) (
    input  logic                    w_clk,
    input  logic                    wrst,
    input  logic                    w_en,
    input  logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE-1:0] w_addr,
    output logic                    w_full,
    output logic                    w_almost_full,
    output logic [ADDRESS_SIZE:0]   w_level,
    output logic                    w_overflow
);

    localparam int A = ADDRESS_SIZE;
    localparam logic [A:0] AF_THRESH = (A+1)'(ALMOST_FULL_THRESH);

    logic [A:0] w_bin_reg;
    logic [A:0] w_ptr_reg;
    logic [A:0] wq1_rptr_reg;
    logic [A:0] wq2_rptr_reg;
    logic       w_full_reg;
    logic       w_almost_full_reg;
    logic [A:0] w_level_reg;

    logic       w_inc;
    logic [A:0] w_bnext;
    logic [A:0] w_gnext;
    logic [A:0] wq2_rbin;
    logic [A:0] level_next;
    logic       full_next;
    logic       almost_full_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi <= A; gi++) begin : g_gray2bin
            assign wq2_rbin[gi] = ^wq2_rptr_reg[A:gi];
        end
    endgenerate

    assign w_inc            = w_en & ~w_full_reg;
    assign w_bnext          = w_bin_reg + (A+1)'(w_inc);
    assign w_gnext          = w_bnext ^ (w_bnext >> 1);
    assign level_next       = w_bnext - wq2_rbin;
    // Full when the next write pointer is exactly one lap ahead of the synchronised read pointer.
    assign full_next        = (w_gnext == {~wq2_rptr_reg[A:A-1], wq2_rptr_reg[A-2:0]});
    assign almost_full_next = (level_next >= AF_THRESH);

    always_ff @(posedge w_clk) begin
        if (wrst) begin
            w_bin_reg         <= '0;
            w_ptr_reg         <= '0;
            wq1_rptr_reg      <= '0;
            wq2_rptr_reg      <= '0;
            w_full_reg        <= 1'b0;
            w_almost_full_reg <= 1'b0;
            w_level_reg       <= '0;
        end else begin
            w_bin_reg         <= w_bnext;
            w_ptr_reg         <= w_gnext;
            wq1_rptr_reg      <= r_ptr;
            wq2_rptr_reg      <= wq1_rptr_reg;
            w_full_reg        <= full_next;
            w_almost_full_reg <= almost_full_next;
            w_level_reg       <= level_next;
        end
    end

`ifdef W_OVERFLOW_DETECT_EN
    logic w_overflow_reg;

    // Sticky until reset: any write attempt against a full FIFO is recorded.
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            w_overflow_reg <= 1'b0;
        end else if (w_en && w_full_reg) begin
            w_overflow_reg <= 1'b1;
        end
    end

    assign w_overflow = w_overflow_reg;
`else
    assign w_overflow = 1'b0;
`endif

    assign w_ptr         = w_ptr_reg;
    assign w_addr        = w_bin_reg[A-1:0];
    assign w_full        = w_full_reg;
    assign w_almost_full = w_almost_full_reg;
    assign w_level       = w_level_reg;

endmodule

// File: tb/tb_w_clk_module.sv
// Directed bench for w_clk_module with ADDRESS_SIZE=3, ALMOST_FULL_THRESH=6:
// reset, fill, reader progress latency, pointer wrap, mid-run reset and overflow flag.
module tb_w_clk_module;

    logic       w_clk;
    logic       wrst;
    logic       w_en;
    logic [3:0] r_ptr;
    logic [3:0] w_ptr;
    logic [2:0] w_addr;
    logic       w_full;
    logic       w_almost_full;
    logic [3:0] w_level;
    logic       w_overflow;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef W_OVERFLOW_DETECT_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    // Gray codes of binary 1..8 on a 4-bit pointer.
    logic [3:0] gray_tab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100};

    w_clk_module #(
        .ADDRESS_SIZE       (3),
        .ALMOST_FULL_THRESH (6)
    ) dut (
        .w_clk         (w_clk),
        .wrst          (wrst),
        .w_en          (w_en),
        .r_ptr         (r_ptr),
        .w_ptr         (w_ptr),
        .w_addr        (w_addr),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_level       (w_level),
        .w_overflow    (w_overflow)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        wrst  = 1'b1;
        w_en  = 1'b1;
        r_ptr = 4'b0000;
        tick();
        tick();
        chk("rst_wptr",  w_ptr, 0);
        chk("rst_addr",  w_addr, 0);
        chk("rst_full",  w_full, 0);
        chk("rst_af",    w_almost_full, 0);
        chk("rst_level", w_level, 0);
        chk("rst_ovf",   w_overflow, 0);

        // Fill an empty FIFO with eight back-to-back writes.
        wrst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("fill_addr", w_addr, i);
            tick();
            $display("fill write %0d: w_ptr=%b level=%0d af=%b full=%b",
                     i, w_ptr, w_level, w_almost_full, w_full);
            chk("fill_level", w_level, i + 1);
            chk("fill_wptr",  w_ptr, gray_tab[i]);
            chk("fill_af",    w_almost_full, (i + 1 >= 6) ? 1 : 0);
            chk("fill_full",  w_full, (i == 7) ? 1 : 0);
        end
        chk("fill_ovf", w_overflow, 0);

        // Two writes against a full FIFO are ignored.
        for (int i = 0; i < 2; i++) begin
            tick();
            $display("rejected write %0d: w_ptr=%b addr=%0d", i, w_ptr, w_addr);
            chk("rej_addr",  w_addr, 0);
            chk("rej_wptr",  w_ptr, 4'b1100);
            chk("rej_level", w_level, 8);
            chk("rej_full",  w_full, 1);
            chk("rej_ovf",   w_overflow, OVF_EN);
        end

        // Reader reaches binary 2: full clears on the third edge.
        w_en  = 1'b0;
        r_ptr = 4'b0011;
        tick();
        chk("rd2_full_e1", w_full, 1);
        tick();
        chk("rd2_full_e2", w_full, 1);
        tick();
        $display("read ptr 2 seen: level=%0d af=%b full=%b", w_level, w_almost_full, w_full);
        chk("rd2_full_e3", w_full, 0);
        chk("rd2_level",   w_level, 6);
        chk("rd2_af",      w_almost_full, 1);

        // Reader reaches binary 3.
        r_ptr = 4'b0010;
        tick();
        tick();
        chk("rd3_level_e2", w_level, 6);
        tick();
        $display("read ptr 3 seen: level=%0d af=%b", w_level, w_almost_full);
        chk("rd3_level", w_level, 5);
        chk("rd3_af",    w_almost_full, 0);
        chk("rd3_ovf",   w_overflow, OVF_EN);

        // Reader advances to binary 8, draining the FIFO.
        r_ptr = 4'b0110; tick();
        r_ptr = 4'b0111; tick();
        r_ptr = 4'b0101; tick();
        r_ptr = 4'b0100; tick();
        r_ptr = 4'b1100; tick();
        tick();
        tick();
        chk("drain_level", w_level, 0);
        chk("drain_full",  w_full, 0);
        chk("drain_af",    w_almost_full, 0);

        // Eight more writes take the write pointer across the wrap to zero.
        w_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("wrap_addr", w_addr, i);
            tick();
            $display("wrap write %0d: w_ptr=%b level=%0d af=%b full=%b",
                     i, w_ptr, w_level, w_almost_full, w_full);
            chk("wrap_level", w_level, i + 1);
            chk("wrap_af",    w_almost_full, (i + 1 >= 6) ? 1 : 0);
            chk("wrap_full",  w_full, (i == 7) ? 1 : 0);
        end
        chk("wrap_wptr", w_ptr, 4'b0000);
        chk("wrap_addr0", w_addr, 0);
        tick();
        chk("wrap_rej_wptr",  w_ptr, 4'b0000);
        chk("wrap_rej_addr",  w_addr, 0);
        chk("wrap_rej_level", w_level, 8);

        // Reader to binary 11 (Gray 1110) leaves level 5.
        w_en  = 1'b0;
        r_ptr = 4'b1110;
        tick();
        tick();
        tick();
        chk("pre_rst_level", w_level, 5);
        chk("pre_rst_full",  w_full, 0);
        chk("pre_rst_af",    w_almost_full, 0);

        // One-edge reset with a write pending.
        w_en  = 1'b1;
        wrst  = 1'b1;
        r_ptr = 4'b0000;
        tick();
        $display("mid reset: w_ptr=%b addr=%0d level=%0d", w_ptr, w_addr, w_level);
        chk("mrst_wptr",  w_ptr, 0);
        chk("mrst_addr",  w_addr, 0);
        chk("mrst_level", w_level, 0);
        chk("mrst_full",  w_full, 0);
        chk("mrst_af",    w_almost_full, 0);
        chk("mrst_ovf",   w_overflow, 0);

        wrst = 1'b0;
        w_en = 1'b0;
        tick();
        tick();
        tick();
        chk("post_rst_full",  w_full, 0);
        chk("post_rst_level", w_level, 0);
        w_en = 1'b1;
        tick();
        w_en = 1'b0;
        $display("post reset write: w_ptr=%b addr=%0d level=%0d", w_ptr, w_addr, w_level);
        chk("post_wr_level", w_level, 1);
        chk("post_wr_addr",  w_addr, 1);
        chk("post_wr_wptr",  w_ptr, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/w_clk_module.md
Name: w_clk_module

Overview:
Write-side pointer/flag block of the dual-clock FIFO, the counterpart to the read-side module.
- Holds the binary write address and the Gray write pointer.
- Synchronises the read-domain Gray pointer into w_clk.
- Produces registered full, almost-full and occupancy-level outputs for the producer and the dual-port memory write port.

Parameters:
ADDRESS_SIZE, 4, memory address width; depth DEPTH = 2**ADDRESS_SIZE; must be >= 2
ALMOST_FULL_THRESH, 2**ADDRESS_SIZE - 2, occupancy at or above which w_almost_full asserts; legal range 1..DEPTH

Ports:
w_clk  input  1  write-domain clock; the only clock
wrst  input  1  synchronous, active-high reset (sampled on posedge w_clk)
w_en  input  1  write request from producer
r_ptr  input  ADDRESS_SIZE+1  Gray read pointer from read domain (asynchronous to w_clk)
w_ptr  output  ADDRESS_SIZE+1  registered Gray write pointer to read domain
w_addr  output  ADDRESS_SIZE  memory write address = w_bin[ADDRESS_SIZE-1:0]
w_full  output  1  registered full flag
w_almost_full  output  1  registered almost-full flag
w_level  output  ADDRESS_SIZE+1  registered occupancy, 0..DEPTH, pessimistic
w_overflow  output  1  sticky overflow error (only with W_OVERFLOW_DETECT_EN)

Behaviour:
- Reset (wrst=1 at posedge): w_bin=0, w_ptr=0, w_full=0, w_almost_full=0, w_level=0, both synchroniser stages=0, w_overflow=0.
  - Reset has priority over every other event; w_en is ignored while wrst=1.
- Write acceptance: w_inc = w_en & !w_full, same cycle, no enable delay flop.
  - Memory writes at w_addr on the same posedge; w_bin advances on that edge.
- Next-state values:
  - w_bnext = w_bin + w_inc, modulo 2**(ADDRESS_SIZE+1).
  - w_gnext = w_bnext ^ (w_bnext >> 1).
  - w_ptr <= w_gnext.
- Synchroniser: two-flop chain on r_ptr, all bits registered in parallel, output wq2_rptr.
  - wq2_rbin = Gray-to-binary of wq2_rptr (combinational XOR prefix).
- Full: w_full <= (w_gnext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDRESS_SIZE.
- Level: w_level <= (w_bnext - wq2_rbin) mod 2**(A+1).
  - This never exceeds DEPTH.
  - w_full is equivalent to level_next == DEPTH.
- Almost-full: w_almost_full <= (level_next >= ALMOST_FULL_THRESH).
- Latency, reader progress: a change on r_ptr that is stable before posedge k is reflected in w_full / w_level / w_almost_full after posedge k+2 (third edge).
  - The flags are therefore pessimistic. Full may stay high up to 3 cycles after space frees; it never falsely deasserts.
- Latency, own writes: the flags include the current write on the same edge.
  - The write that fills the FIFO raises w_full on the edge that accepts it.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0 (Gray 10..0 to 0..0). Full, level and almost-full stay correct across the wrap.
- Simultaneous write accepted and read progress observed on the same edge: both terms are used in level_next. Net occupancy change is +1 for the write, minus the synchronised read delta.
- w_en while full: no pointer change, no memory write, no flag change (except w_overflow if enabled).
- Reset mid-operation: all state clears on the next edge regardless of level.
  - The read side must be reset together with this block; pointers mismatched across domains are not supported.

Optional Feature:
W_OVERFLOW_DETECT_EN
- Defined:
  - w_overflow is a register that sets on any posedge with w_en=1 and w_full=1.
  - It holds until wrst.
  - It is observable the cycle after the offending edge.
- Undefined:
  - Port w_overflow is still present, tied to 0.
  - No extra register is synthesised.
  - Write-rejection behaviour is unchanged in both cases.

Test Plan:
1. ADDRESS_SIZE=3, ALMOST_FULL_THRESH=6; hold wrst=1 for 2 edges with w_en=1 -> w_ptr=0000, w_addr=0, w_full=0, w_almost_full=0, w_level=0; no pointer advance.
2. r_ptr=0000, w_en=1 for 10 cycles:
   - w_addr steps 0..7.
   - w_almost_full=1 after 6th accepted write (w_level=6).
   - w_full=1 after 8th (w_level=8, w_ptr=1100).
   - Cycles 9-10 ignored: w_addr stays 0, w_ptr stays 1100.
3. From state 2, drive r_ptr=0011 (binary 2), w_en=0 -> w_full falls after the 3rd w_clk edge; w_level=6; w_almost_full remains 1. Then r_ptr=0010 (binary 3) -> w_level=5, w_almost_full=0 three edges later.
4. Wrap test:
   - Step r_ptr through Gray of 1..8 (ending at 1100) while continuing writes until w_bin wraps to 0 (w_ptr=0000).
   - Then w_full=1 (compare {~1,~1,0,0}=0000), w_level=8, w_addr=0.
   - Further writes are rejected.
5. Mid-operation reset: at w_level=5, w_en=1, pulse wrst for one edge -> next cycle w_ptr=0, w_addr=0, w_level=0, all flags 0. A stale r_ptr=0000 then gives no spurious full.
6. W_OVERFLOW_DETECT_EN defined: fill to full, assert w_en one extra cycle -> w_overflow=1 next cycle, stays 1 after w_en drops and after reads free space, clears only on wrst. Without the macro -> w_overflow constant 0.
